instr_stream_encoder: RTL and testbench

- Sequential instruction encoder and loader: the encode-side counterpart of the main control decoder.
- Accepts symbolic instructions (op, register fields, immediate) over a valid/ready handshake and packs them into 32-bit MIPS words (R-format add/sub/and/or/slt, lw, sw, beq, nop).
- Writes each word into instruction memory at consecutive word addresses from BASE_ADDR, using a we/ack handshake.
- Used by benches and boot logic to fill instruction memory before the single-cycle core runs.

---
 rtl/instr_stream_encoder_if.sv | 38 +++
 rtl/instr_stream_encoder.sv | 130 +++++++++++++
 tb/tb_instr_stream_encoder.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/instr_stream_encoder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : instr_stream_encoder_if                                         |
// | Purpose  : Request handshake and instruction-memory write bus for the      |
// |            instruction stream encoder.                                     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface instr_stream_encoder_if #(
    parameter int CNT_W = 9
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_op;
    logic [4:0]       in_rs;
    logic [4:0]       in_rt;
    logic [4:0]       in_rd;
    logic [15:0]      in_imm;
    logic             in_last;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic             mem_ack;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_last, mem_ack,
        input  in_ready, mem_we, mem_addr, mem_wdata, count, busy, done, err
    );

    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_last, mem_ack,
        output in_ready, mem_we, mem_addr, mem_wdata, count, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/instr_stream_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : instr_stream_encoder                                            |
// | Purpose  : Packs symbolic MIPS instructions into words and writes them to  |
// |            consecutive instruction-memory addresses.                       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module instr_stream_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 256,
    parameter int          CNT_W     = 9
) (
    input  wire logic              clk,
    input  wire logic              rst,
    instr_stream_encoder_if.slave  bus
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_SLT = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SW  = 4'd6;
    localparam logic [3:0] OP_BEQ = 4'd7;
    localparam logic [3:0] OP_NOP = 4'd8;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] OPC_LW  = 6'b100011;
    localparam logic [5:0] OPC_SW  = 6'b101011;
    localparam logic [5:0] OPC_BEQ = 6'b000100;

    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             last_q, last_d;

    logic [31:0]      enc_word;
    logic             enc_legal;
    logic [CNT_W-1:0] count_inc;

    always_comb begin
        enc_word  = 32'h0000_0000;
        enc_legal = 1'b1;
        case (bus.in_op)
            OP_ADD:  enc_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b00000, FN_ADD};
            OP_SUB:  enc_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b00000, FN_SUB};
            OP_AND:  enc_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b00000, FN_AND};
            OP_OR:   enc_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b00000, FN_OR};
            OP_SLT:  enc_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b00000, FN_SLT};
            OP_LW:   enc_word = {OPC_LW,  bus.in_rs, bus.in_rt, bus.in_imm};
            OP_SW:   enc_word = {OPC_SW,  bus.in_rs, bus.in_rt, bus.in_imm};
            OP_BEQ:  enc_word = {OPC_BEQ, bus.in_rs, bus.in_rt, bus.in_imm};
            OP_NOP:  enc_word = 32'h0000_0000;
            default: enc_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        count_d   = count_q;
        last_d    = last_q;
        count_inc = count_q + 1'b1;
        case (state_q)
            ST_IDLE: begin
                // Illegal ops leave the word register untouched; nothing is written.
                if (bus.in_valid) begin
                    if (enc_legal) begin
                        wdata_d = enc_word;
                        last_d  = bus.in_last;
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_WRITE: begin
                if (bus.mem_ack) begin
                    addr_d  = addr_q + 32'd4;
                    count_d = count_inc;
                    state_d = (last_q || (count_inc == C_DEPTH)) ? ST_DONE : ST_IDLE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= BASE_ADDR;
            wdata_q <= 32'h0000_0000;
            count_q <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            last_q  <= last_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.mem_we    = (state_q == ST_WRITE);
    assign bus.busy      = (state_q == ST_WRITE);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.err       = (state_q == ST_ERR);
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.count     = count_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_stream_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_instr_stream_encoder                                         |
// | Purpose  : Directed self-checking bench for instr_stream_encoder.          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_instr_stream_encoder;

    logic clk;
    logic rst;

    int vec_cnt = 0;
    int err_cnt = 0;

    instr_stream_encoder_if #(.CNT_W(9)) if0 ();
    instr_stream_encoder_if #(.CNT_W(9)) if4 ();

    instr_stream_encoder #(.BASE_ADDR(32'h0), .DEPTH(256), .CNT_W(9)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    instr_stream_encoder #(.BASE_ADDR(32'h0), .DEPTH(4), .CNT_W(9)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] wr4_addr[$];
    logic [31:0] wr4_data[$];
    always @(posedge clk) begin
        if (!rst && if4.mem_we && if4.mem_ack) begin
            wr4_addr.push_back(if4.mem_addr);
            wr4_data.push_back(if4.mem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        if0.in_valid = 1'b0;
        if0.mem_ack  = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic write_instr(input string tag, input logic [3:0] op, input logic [4:0] rs,
                               input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                               input logic last, input int ack_dly, input logic [31:0] exp_data,
                               input logic [31:0] exp_addr, input logic [8:0] exp_cnt);
        int n = 0;
        while (!if0.in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_rdy"}, 32'(if0.in_ready), 32'd1);
        if0.in_op    = op;
        if0.in_rs    = rs;
        if0.in_rt    = rt;
        if0.in_rd    = rd;
        if0.in_imm   = imm;
        if0.in_last  = last;
        if0.in_valid = 1'b1;
        @(posedge clk); #1;
        if0.in_valid = 1'b0;
        for (int k = 0; k <= ack_dly; k++) begin
            check({tag, "_we"},    32'(if0.mem_we),   32'd1);
            check({tag, "_busy"},  32'(if0.busy),     32'd1);
            check({tag, "_nrdy"},  32'(if0.in_ready), 32'd0);
            check({tag, "_addr"},  if0.mem_addr,      exp_addr);
            check({tag, "_data"},  if0.mem_wdata,     exp_data);
            check({tag, "_cntw"},  32'(if0.count),    32'(exp_cnt - 9'd1));
            if (k == ack_dly) if0.mem_ack = 1'b1;
            @(posedge clk); #1;
            if0.mem_ack = 1'b0;
        end
        check({tag, "_cnt"},  32'(if0.count),    32'(exp_cnt));
        check({tag, "_we0"},  32'(if0.mem_we),   32'd0);
        check({tag, "_done"}, 32'(if0.done),     32'(last));
        check({tag, "_rdyn"}, 32'(if0.in_ready), 32'(!last));
    endtask

    initial begin
        rst = 1'b1;
        if0.in_valid = 1'b0; if0.in_op = 4'd0; if0.in_rs = 5'd0; if0.in_rt = 5'd0;
        if0.in_rd = 5'd0; if0.in_imm = 16'd0; if0.in_last = 1'b0; if0.mem_ack = 1'b0;
        if4.in_valid = 1'b0; if4.in_op = 4'd0; if4.in_rs = 5'd0; if4.in_rt = 5'd0;
        if4.in_rd = 5'd0; if4.in_imm = 16'd0; if4.in_last = 1'b0; if4.mem_ack = 1'b0;

        // Reset state
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_we",    32'(if0.mem_we),  32'd0);
        check("rst_addr",  if0.mem_addr,     32'h0);
        check("rst_wdata", if0.mem_wdata,    32'h0);
        check("rst_cnt",   32'(if0.count),   32'd0);
        check("rst_busy",  32'(if0.busy),    32'd0);
        check("rst_done",  32'(if0.done),    32'd0);
        check("rst_err",   32'(if0.err),     32'd0);
        rst = 1'b0;
        check("rst_rdy",   32'(if0.in_ready), 32'd1);

        // Single ADD, last, immediate ack; DONE then ignores in_valid
        write_instr("add", 4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 1'b1, 0, 32'h0022_1820, 32'h0, 9'd1);
        if0.in_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        if0.in_valid = 1'b0;
        check("done_we",   32'(if0.mem_we), 32'd0);
        check("done_cnt",  32'(if0.count),  32'd1);
        check("done_stk",  32'(if0.done),   32'd1);

        // LW / SW / BEQ stream
        do_reset();
        write_instr("lw",  4'd5, 5'd0, 5'd8, 5'd31, 16'h0004, 1'b0, 0, 32'h8C08_0004, 32'h0, 9'd1);
        write_instr("sw",  4'd6, 5'd0, 5'd9, 5'd31, 16'h0008, 1'b0, 1, 32'hAC09_0008, 32'h4, 9'd2);
        write_instr("beq", 4'd7, 5'd8, 5'd9, 5'd0,  16'hFFFE, 1'b1, 0, 32'h1109_FFFE, 32'h8, 9'd3);

        // Delayed ack; SLT with stray imm afterwards
        do_reset();
        write_instr("sub", 4'd1, 5'd4, 5'd5, 5'd6, 16'hFFFF, 1'b0, 3, 32'h0085_3022, 32'h0, 9'd1);
        write_instr("slt", 4'd4, 5'd7, 5'd8, 5'd9, 16'h1234, 1'b1, 0, 32'h00E8_482A, 32'h4, 9'd2);

        // Illegal op after a NOP
        do_reset();
        write_instr("nop", 4'd8, 5'd3, 5'd3, 5'd3, 16'h5555, 1'b0, 0, 32'h0, 32'h0, 9'd1);
        if0.in_op = 4'd12;
        if0.in_valid = 1'b1;
        @(posedge clk); #1;
        if0.in_op = 4'd0;
        for (int k = 0; k < 3; k++) begin
            check("ill_err",  32'(if0.err),      32'd1);
            check("ill_we",   32'(if0.mem_we),   32'd0);
            check("ill_cnt",  32'(if0.count),    32'd1);
            check("ill_rdy",  32'(if0.in_ready), 32'd0);
            check("ill_addr", if0.mem_addr,      32'h4);
            @(posedge clk); #1;
        end
        if0.in_valid = 1'b0;

        // Reset while a write is in flight
        do_reset();
        if0.in_op = 4'd4; if0.in_rs = 5'd7; if0.in_rt = 5'd8; if0.in_rd = 5'd9; if0.in_last = 1'b0;
        if0.in_valid = 1'b1;
        @(posedge clk); #1;
        if0.in_valid = 1'b0;
        check("rw_we1", 32'(if0.mem_we), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rw_we0",  32'(if0.mem_we), 32'd0);
        check("rw_addr", if0.mem_addr,    32'h0);
        check("rw_cnt",  32'(if0.count),  32'd0);
        check("rw_done", 32'(if0.done),   32'd0);
        check("rw_err",  32'(if0.err),    32'd0);
        write_instr("and", 4'd2, 5'd1, 5'd1, 5'd2, 16'h0, 1'b1, 0, 32'h0021_1024, 32'h0, 9'd1);

        // DEPTH=4 instance: six ORs offered, only four may be written
        do_reset();
        if4.in_op = 4'd3; if4.in_rs = 5'd3; if4.in_rt = 5'd4; if4.in_rd = 5'd5; if4.in_last = 1'b0;
        if4.mem_ack  = 1'b1;
        if4.in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
        end
        if4.in_valid = 1'b0;
        if4.mem_ack  = 1'b0;
        check("d4_nwr",  32'(wr4_addr.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < wr4_addr.size()) begin
                check("d4_addr", wr4_addr[k], 32'(k * 4));
                check("d4_data", wr4_data[k], 32'h0064_2825);
            end
        end
        check("d4_cnt",  32'(if4.count),    32'd4);
        check("d4_done", 32'(if4.done),     32'd1);
        check("d4_rdy",  32'(if4.in_ready), 32'd0);
        check("d4_addr_end", if4.mem_addr,  32'h10);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
`default_nettype wire
